// File: rtl/systolic_feeder_if.sv
// ============================================================================
// systolic_feeder_if : operand-load and skewed-stream bundle for systolic_feeder
// Revision 1.0
// ============================================================================
`default_nettype none

interface systolic_feeder_if #(
  parameter int DATA_BIT = 8
);
  logic                wr_en;
  logic                wr_sel;
  logic [3:0]          wr_addr;
  logic [DATA_BIT-1:0] wr_data;
  logic                start;
  logic                busy;
  logic                done;
  logic                acc_clr;
  logic [DATA_BIT-1:0] input_west0;
  logic [DATA_BIT-1:0] input_west4;
  logic [DATA_BIT-1:0] input_west8;
  logic [DATA_BIT-1:0] input_west12;
  logic [DATA_BIT-1:0] input_north0;
  logic [DATA_BIT-1:0] input_north1;
  logic [DATA_BIT-1:0] input_north2;
  logic [DATA_BIT-1:0] input_north3;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, done, acc_clr,
    input  input_west0, input_west4, input_west8, input_west12,
    input  input_north0, input_north1, input_north2, input_north3
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, done, acc_clr,
    output input_west0, input_west4, input_west8, input_west12,
    output input_north0, input_north1, input_north2, input_north3
  );
endinterface

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
// systolic_feeder : holds 4x4 A/B operands and feeds them diagonally skewed
// Revision 1.0
// ============================================================================
`default_nettype none

module systolic_feeder #(
  parameter int DATA_BIT = 8
) (
  input  wire                 clk,
  input  wire                 rst,
  systolic_feeder_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          t_q, t_d;
  logic [1:0]          dcnt_q, dcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                acc_clr_q, acc_clr_d;
  logic                feed_d;

  logic [DATA_BIT-1:0] a_q [16];
  logic [DATA_BIT-1:0] b_q [16];
  logic [DATA_BIT-1:0] west_q  [4];
  logic [DATA_BIT-1:0] north_q [4];
  logic [DATA_BIT-1:0] west_d  [4];
  logic [DATA_BIT-1:0] north_d [4];

  // Writes are accepted only when no sequence is reading the storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < 16; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
      end
    end else if (bus.wr_en && !busy_q) begin
      if (bus.wr_sel) b_q[bus.wr_addr] <= bus.wr_data;
      else            a_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      dcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        west_q[n]  <= '0;
        north_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      dcnt_q    <= dcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_clr_q <= acc_clr_d;
      for (int n = 0; n < 4; n++) begin
        west_q[n]  <= west_d[n];
        north_q[n] <= north_d[n];
      end
    end
  end

  // Outputs are decoded from the next state so that every output is a flop.
  always_comb begin
    state_d = state_q;
    t_d     = '0;
    dcnt_d  = '0;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (t_q == 3'd6) state_d = S_DRAIN;
        else             t_d     = t_q + 3'd1;
      end
      S_DRAIN: begin
        if (dcnt_q == 2'd3) state_d = S_DONE;
        else                dcnt_d  = dcnt_q + 2'd1;
      end
      S_DONE:  state_d = bus.start ? S_CLEAR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d    = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
    acc_clr_d = (state_d == S_CLEAR);
    feed_d    = (state_d == S_FEED);
  end

  // Lane g is delayed by g cycles; dly = t - g must land in 0..3 to be live.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam logic [3:0] LANE_IDX = 4'(g);
    logic [3:0] dly;
    logic       hit;
    assign dly        = {1'b0, t_d} - LANE_IDX;
    assign hit        = feed_d && (dly[3:2] == 2'b00);
    assign west_d[g]  = hit ? a_q[{LANE_IDX[1:0], dly[1:0]}] : '0;
    assign north_d[g] = hit ? b_q[{dly[1:0], LANE_IDX[1:0]}] : '0;
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.acc_clr      = acc_clr_q;
  assign bus.input_west0  = west_q[0];
  assign bus.input_west4  = west_q[1];
  assign bus.input_west8  = west_q[2];
  assign bus.input_west12 = west_q[3];
  assign bus.input_north0 = north_q[0];
  assign bus.input_north1 = north_q[1];
  assign bus.input_north2 = north_q[2];
  assign bus.input_north3 = north_q[3];

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ============================================================================
// tb_systolic_feeder : table-driven check of skew, handshake and abort paths
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_systolic_feeder;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            clr;
    logic [3:0][7:0] w;
    logic [3:0][7:0] n;
  } exp_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  exp_t tbl [14];

  systolic_feeder_if #(.DATA_BIT(8)) bus ();

  systolic_feeder #(.DATA_BIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(bit b, bit d, bit c,
                              int w0, int w1, int w2, int w3,
                              int n0, int n1, int n2, int n3);
    exp_t r;
    r.busy = b;  r.done = d;  r.clr = c;
    r.w[0] = 8'(w0); r.w[1] = 8'(w1); r.w[2] = 8'(w2); r.w[3] = 8'(w3);
    r.n[0] = 8'(n0); r.n[1] = 8'(n1); r.n[2] = 8'(n2); r.n[3] = 8'(n3);
    return r;
  endfunction

  function automatic exp_t act();
    exp_t r;
    r.busy = bus.busy;  r.done = bus.done;  r.clr = bus.acc_clr;
    r.w[0] = bus.input_west0;  r.w[1] = bus.input_west4;
    r.w[2] = bus.input_west8;  r.w[3] = bus.input_west12;
    r.n[0] = bus.input_north0; r.n[1] = bus.input_north1;
    r.n[2] = bus.input_north2; r.n[3] = bus.input_north3;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [66:0] got, input logic [66:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = 4'(addr);
    bus.wr_data = 8'(data);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Pulses start for one edge (E0) and compares cycles E0..E13 to the table.
  task automatic run_tbl(input bit zero, input bit wr_mid, input string nm);
    exp_t e;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) tick();
      e = tbl[k];
      if (zero) begin
        e.w = '0;
        e.n = '0;
      end
      chk($sformatf("%s_k%0d", nm, k), act(), e);
      if (wr_mid && k == 3) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 8'd99;
      end else begin
        bus.wr_en = 1'b0;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;

    tbl[0]  = mk(1,0,1,  0, 0, 0, 0,  0,0,0,0);
    tbl[1]  = mk(1,0,0,  1, 0, 0, 0,  1,0,0,0);
    tbl[2]  = mk(1,0,0,  2, 5, 0, 0,  0,0,0,0);
    tbl[3]  = mk(1,0,0,  3, 6, 9, 0,  0,1,0,0);
    tbl[4]  = mk(1,0,0,  4, 7,10,13,  0,0,0,0);
    tbl[5]  = mk(1,0,0,  0, 8,11,14,  0,0,1,0);
    tbl[6]  = mk(1,0,0,  0, 0,12,15,  0,0,0,0);
    tbl[7]  = mk(1,0,0,  0, 0, 0,16,  0,0,0,1);
    tbl[8]  = mk(1,0,0,  0, 0, 0, 0,  0,0,0,0);
    tbl[9]  = tbl[8];
    tbl[10] = tbl[8];
    tbl[11] = tbl[8];
    tbl[12] = mk(0,1,0,  0, 0, 0, 0,  0,0,0,0);
    tbl[13] = mk(0,0,0,  0, 0, 0, 0,  0,0,0,0);

    repeat (2) tick();
    rst = 1'b1;
    tick();
    wr(1'b0, 0, 55);
    wr(1'b1, 0, 55);

    // Reset held with start and a write both asserted.
    rst         = 1'b0;
    bus.start   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'd77;
    repeat (3) tick();
    chk("reset_hold", act(), mk(0,0,0, 0,0,0,0, 0,0,0,0));
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("reset_idle", act(), mk(0,0,0, 0,0,0,0, 0,0,0,0));
    run_tbl(1'b1, 1'b0, "zero_run");

    for (int n = 0; n < 16; n++) begin
      wr(1'b0, n, (n == 0) ? 77 : n + 1);
      wr(1'b1, n, (n % 5 == 0) ? 1 : 0);
    end

    // A[0] rewritten on the start edge: the run must see the new value 1.
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = 8'd1;
    run_tbl(1'b0, 1'b1, "skew");
    run_tbl(1'b0, 1'b0, "after_blocked_wr");

    // Back-to-back with start held: done every 13 cycles, acc_clr right after.
    bus.start = 1'b1;
    tick();
    for (int k = 0; k < 39; k++) begin
      if (k > 0) tick();
      chk($sformatf("b2b_k%0d", k), {65'd0, bus.done, bus.acc_clr},
          {65'd0, (k % 13 == 12), (k % 13 == 0)});
    end
    bus.start = 1'b0;
    tick();
    chk("b2b_stop", act(), mk(0,0,0, 0,0,0,0, 0,0,0,0));

    // Asynchronous abort at t=4, between clock edges.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("abort_pre", act(), tbl[5]);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_now", act(), mk(0,0,0, 0,0,0,0, 0,0,0,0));
    #3;
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("abort_quiet_k%0d", k), {64'd0, bus.busy, bus.done, bus.acc_clr}, 67'd0);
    end
    run_tbl(1'b1, 1'b0, "post_abort_zero");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
